// File: rtl/data_mem_bus_if.sv
// data_mem_bus_if: CPU data-side bus (write strobe, byte address, write/read data).
interface data_mem_bus_if;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_data_in;
    logic [31:0] dm_data_out;

    modport master (output dm_write, dm_addr, dm_data_in, input dm_data_out);
    modport slave  (input dm_write, dm_addr, dm_data_in, output dm_data_out);
endinterface

// File: rtl/data_mem_bus.sv
// data_mem_bus: CPU data memory decode into word RAM, LED/switch MMIO and a prescaled compare timer.
module data_mem_bus #(
    parameter int RAM_AW   = 10,
    parameter int PRESCALE = 4
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_bus_if.slave      bus,
    input  logic [15:0]        sw_in,
    output logic [15:0]        led_out,
    output logic               timer_irq,
    output logic               bus_err
);
    localparam logic [29:0] MMIO_BASE = 30'h3FFF_C000;
    localparam logic [15:0] PRE_LAST  = 16'(PRESCALE - 1);

    logic [29:0]       word;
    logic [RAM_AW-1:0] ram_idx;
    logic              sel_ram, sel_led, sel_sw, sel_tcnt, sel_tcmp, sel_tctl;
    logic              wr, tick, hit, addr_unused;
    logic [31:0]       din;
    logic [31:0]       ram [0:(1<<RAM_AW)-1];

    logic [15:0] led_q, led_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic [31:0] tcmp_q, tcmp_d;
    logic [15:0] pre_q, pre_d;
    logic        en_q, en_d, auto_clr_q, auto_clr_d, irq_en_q, irq_en_d;
    logic        match_q, match_d;
    logic [15:0] sw_meta_q, sw_sync_q;
    logic        bus_err_q, bus_err_d;

    assign word        = bus.dm_addr[31:2];
    assign ram_idx     = bus.dm_addr[RAM_AW+1:2];
    assign addr_unused = ^bus.dm_addr[1:0];
    assign din         = bus.dm_data_in;
    assign wr          = bus.dm_write;
    assign sel_ram     = bus.dm_addr[31:RAM_AW+2] == '0;
    assign sel_led     = word == MMIO_BASE;
    assign sel_sw      = word == MMIO_BASE + 30'd1;
    assign sel_tcnt    = word == MMIO_BASE + 30'd2;
    assign sel_tcmp    = word == MMIO_BASE + 30'd3;
    assign sel_tctl    = word == MMIO_BASE + 30'd4;

    always_comb begin
        tick       = en_q && pre_q == PRE_LAST;
        hit        = tick && tcnt_q == tcmp_q;
        led_d      = (wr && sel_led) ? din[15:0] : led_q;
        tcmp_d     = (wr && sel_tcmp) ? din : tcmp_q;
        // CPU writes to TCNT override both increment and auto-clear, and restart the prescaler
        tcnt_d     = (wr && sel_tcnt) ? din : (hit && auto_clr_q) ? 32'd0 : tick ? tcnt_q + 32'd1 : tcnt_q;
        pre_d      = (wr && sel_tcnt) || tick ? 16'd0 : en_q ? pre_q + 16'd1 : pre_q;
        en_d       = (wr && sel_tctl) ? din[0] : en_q;
        auto_clr_d = (wr && sel_tctl) ? din[1] : auto_clr_q;
        irq_en_d   = (wr && sel_tctl) ? din[2] : irq_en_q;
        match_d    = hit ? 1'b1 : (wr && sel_tctl && din[8]) ? 1'b0 : match_q;
        bus_err_d  = wr && !(sel_ram || sel_led || sel_tcnt || sel_tcmp || sel_tctl);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q      <= '0;
            tcnt_q     <= '0;
            tcmp_q     <= '0;
            pre_q      <= '0;
            en_q       <= 1'b0;
            auto_clr_q <= 1'b0;
            irq_en_q   <= 1'b0;
            match_q    <= 1'b0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            led_q      <= led_d;
            tcnt_q     <= tcnt_d;
            tcmp_q     <= tcmp_d;
            pre_q      <= pre_d;
            en_q       <= en_d;
            auto_clr_q <= auto_clr_d;
            irq_en_q   <= irq_en_d;
            match_q    <= match_d;
            sw_meta_q  <= sw_in;
            sw_sync_q  <= sw_meta_q;
            bus_err_q  <= bus_err_d;
        end
    end

    // RAM has no reset so it keeps contents; writes are only blocked while rst is held
    always_ff @(posedge clk) begin
        if (!rst && wr && sel_ram) ram[ram_idx] <= din;
    end

    assign bus.dm_data_out = sel_ram  ? ram[ram_idx] :
                             sel_led  ? {16'h0, led_q} :
                             sel_sw   ? {16'h0, sw_sync_q} :
                             sel_tcnt ? tcnt_q :
                             sel_tcmp ? tcmp_q :
                             sel_tctl ? {23'h0, match_q, 5'h0, irq_en_q, auto_clr_q, en_q} : 32'h0;

    assign led_out   = led_q;
    assign timer_irq = match_q && irq_en_q;
    assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_data_mem_bus.sv
// tb_data_mem_bus: directed and randomized checks of data_mem_bus against a behavioural model.
module tb_data_mem_bus;
    localparam int P = 4;
    localparam logic [31:0] RAM_BYTES = 32'h1000;
    localparam logic [31:0] LED_A  = 32'hFFFF_0000;
    localparam logic [31:0] SW_A   = 32'hFFFF_0004;
    localparam logic [31:0] TCNT_A = 32'hFFFF_0008;
    localparam logic [31:0] TCMP_A = 32'hFFFF_000C;
    localparam logic [31:0] TCTL_A = 32'hFFFF_0010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] sw_in = '0;
    logic [15:0] led_out;
    logic timer_irq, bus_err;

    data_mem_bus_if bus();

    data_mem_bus #(.RAM_AW(10), .PRESCALE(P)) dut (
        .clk(clk), .rst(rst), .bus(bus), .sw_in(sw_in),
        .led_out(led_out), .timer_irq(timer_irq), .bus_err(bus_err)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] m_ram [int];
    logic [15:0] m_led, m_s1, m_s2;
    logic [31:0] m_tcnt, m_tcmp;
    logic        m_en, m_ac, m_ie, m_match, m_berr;
    int          m_pre;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_led = 0; m_s1 = 0; m_s2 = 0; m_tcnt = 0; m_tcmp = 0;
        m_en = 0; m_ac = 0; m_ie = 0; m_match = 0; m_berr = 0; m_pre = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if (a < RAM_BYTES) return m_ram.exists(int'(a >> 2)) ? m_ram[int'(a >> 2)] : 32'hx;
        if (w == LED_A)  return {16'h0, m_led};
        if (w == SW_A)   return {16'h0, m_s2};
        if (w == TCNT_A) return m_tcnt;
        if (w == TCMP_A) return m_tcmp;
        if (w == TCTL_A) return {23'h0, m_match, 5'h0, m_ie, m_ac, m_en};
        return 32'h0;
    endfunction

    task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        bit tick, hit, is_ram;
        w = a & ~32'h3;
        is_ram = a < RAM_BYTES;
        tick = m_en && m_pre == P - 1;
        hit = tick && m_tcnt == m_tcmp;
        m_berr = we && !(is_ram || w inside {LED_A, TCNT_A, TCMP_A, TCTL_A});
        if (hit) m_match = 1;
        else if (we && w == TCTL_A && d[8]) m_match = 0;
        if (we && w == TCNT_A) begin
            m_tcnt = d;
            m_pre = 0;
        end else begin
            if (tick) m_tcnt = (hit && m_ac) ? 32'h0 : m_tcnt + 1;
            if (m_en) m_pre = (m_pre + 1) % P;
        end
        if (we && w == TCTL_A) {m_ie, m_ac, m_en} = d[2:0];
        if (we && w == TCMP_A) m_tcmp = d;
        if (we && w == LED_A) m_led = d[15:0];
        if (we && is_ram) m_ram[int'(a >> 2)] = d;
        m_s2 = m_s1;
        m_s1 = sw_in;
    endtask

    task automatic do_cycle(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.dm_write = we;
        bus.dm_addr = a;
        bus.dm_data_in = d;
        #1 check("read", bus.dm_data_out, model_read(a));
        @(posedge clk);
        model_step(we, a, d);
        @(negedge clk);
        bus.dm_write = 1'b0;
        check("led_out", {16'h0, led_out}, {16'h0, m_led});
        check("bus_err", {31'h0, bus_err}, {31'h0, m_berr});
        check("timer_irq", {31'h0, timer_irq}, {31'h0, m_match & m_ie});
    endtask

    task automatic expect_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.dm_write = 1'b0;
        bus.dm_addr = a;
        #1 check(tag, bus.dm_data_out, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, TCNT_A, 32'h0);
    endtask

    initial begin
        logic [31:0] a, d;
        bus.dm_write = 1'b0;
        bus.dm_addr = '0;
        bus.dm_data_in = '0;
        model_reset();
        #1;
        check("rst_led", {16'h0, led_out}, 32'h0);
        check("rst_bus_err", {31'h0, bus_err}, 32'h0);
        check("rst_irq", {31'h0, timer_irq}, 32'h0);
        expect_rd("rst_tcnt", TCNT_A, 32'h0);
        expect_rd("rst_tctl", TCTL_A, 32'h0);
        expect_rd("rst_sw", SW_A, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 32'(i * 4), $urandom);

        do_cycle(1'b1, 32'h14, 32'h5555_AAAA);
        do_cycle(1'b1, 32'h10, 32'hDEAD_BEEF);
        expect_rd("ram_10", 32'h10, 32'hDEAD_BEEF);
        expect_rd("ram_13", 32'h13, 32'hDEAD_BEEF);
        expect_rd("ram_14", 32'h14, 32'h5555_AAAA);

        do_cycle(1'b1, LED_A, 32'h1234_ABCD);
        check("led_val", {16'h0, led_out}, 32'h0000_ABCD);
        expect_rd("led_rd", LED_A, 32'h0000_ABCD);
        do_cycle(1'b1, SW_A, 32'h0000_FFFF);
        check("sw_wr_err", {31'h0, bus_err}, 32'h1);
        do_cycle(1'b0, SW_A, 32'h0);
        check("sw_wr_err_end", {31'h0, bus_err}, 32'h0);
        expect_rd("sw_unchanged", SW_A, 32'h0);
        expect_rd("unmapped_rd", 32'h8000_0000, 32'h0);
        do_cycle(1'b1, RAM_BYTES, 32'h1111_2222);
        check("ram_end_err", {31'h0, bus_err}, 32'h1);
        expect_rd("ram_end_rd", RAM_BYTES, 32'h0);

        sw_in = 16'h00F0;
        do_cycle(1'b0, SW_A, 32'h0);
        expect_rd("sw_1edge", SW_A, 32'h0);
        do_cycle(1'b0, SW_A, 32'h0);
        expect_rd("sw_2edge", SW_A, 32'h0000_00F0);

        do_cycle(1'b1, TCMP_A, 32'd3);
        do_cycle(1'b1, TCNT_A, 32'd0);
        do_cycle(1'b1, TCTL_A, 32'h7);
        idle(15);
        expect_rd("tcnt_pre_match", TCNT_A, 32'd3);
        check("irq_pre_match", {31'h0, timer_irq}, 32'h0);
        idle(1);
        expect_rd("tcnt_autoclr", TCNT_A, 32'd0);
        check("irq_match", {31'h0, timer_irq}, 32'h1);
        do_cycle(1'b1, TCTL_A, 32'h107);
        expect_rd("w1c", TCTL_A, 32'h7);
        check("irq_cleared", {31'h0, timer_irq}, 32'h0);
        idle(14);
        do_cycle(1'b1, TCTL_A, 32'h107);
        expect_rd("match_beats_w1c", TCTL_A, 32'h107);
        idle(3);
        do_cycle(1'b1, TCNT_A, 32'h100);
        expect_rd("tcnt_wr_beats_tick", TCNT_A, 32'h100);
        idle(3);
        expect_rd("pre_restart", TCNT_A, 32'h100);
        idle(1);
        expect_rd("tick_after_restart", TCNT_A, 32'h101);

        do_cycle(1'b1, TCMP_A, 32'd5);
        do_cycle(1'b1, TCTL_A, 32'h105);
        do_cycle(1'b1, TCNT_A, 32'hFFFF_FFFF);
        idle(3);
        expect_rd("tcnt_max", TCNT_A, 32'hFFFF_FFFF);
        idle(1);
        expect_rd("tcnt_wrap", TCNT_A, 32'h0);
        expect_rd("wrap_no_match", TCTL_A, 32'h5);

        idle(6);
        #3 rst = 1'b1;
        #1 check("arst_led", {16'h0, led_out}, 32'h0);
        expect_rd("arst_tcnt", TCNT_A, 32'h0);
        expect_rd("arst_tctl", TCTL_A, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        expect_rd("ram_after_rst", 32'h10, 32'hDEAD_BEEF);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) sw_in = 16'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2: begin a = 32'($urandom_range(0, 63)); d = $urandom; do_cycle(1'b1, a, d); end
                3: do_cycle(1'b1, LED_A, $urandom);
                4: do_cycle(1'b1, TCNT_A, 32'($urandom_range(0, 8)));
                5: do_cycle(1'b1, TCMP_A, 32'($urandom_range(0, 8)));
                6: do_cycle(1'b1, TCTL_A, $urandom);
                7: begin
                    case ($urandom_range(0, 2))
                        0: a = SW_A;
                        1: a = RAM_BYTES;
                        default: a = 32'hFFFF_0014;
                    endcase
                    do_cycle(1'b1, a, $urandom);
                end
                default: begin
                    case ($urandom_range(0, 2))
                        0: a = 32'($urandom_range(0, 63));
                        1: a = LED_A + 32'($urandom_range(0, 4) * 4);
                        default: a = 32'h8000_0000;
                    endcase
                    do_cycle(1'b0, a, 32'h0);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_bus.md
# data_mem_bus

Data-side memory subsystem attached directly to the CPU's `dm_write`/`dm_addr`/`dm_data_in`/`dm_data_out` ports. It decodes the ALU-computed address into one of three targets:

- a word-addressed data RAM;
- a 16-bit LED output register and a synchronised switch input;
- a 32-bit prescaled timer with compare-match interrupt flag.

Reads are combinational so the CPU's memory-access state samples data in the same cycle. Writes commit on the rising clock edge.

## Interface

Parameters:
- RAM_AW, 10, RAM word-address width; RAM holds 2^RAM_AW 32-bit words (default 4 KiB).
- PRESCALE, 4, timer tick every PRESCALE clk cycles; legal range 1..65535.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- dm_write  in  1  write strobe from CPU; one write per posedge while high.
- dm_addr  in  32  byte address from CPU ALU result; bits [1:0] ignored (word access only).
- dm_data_in  in  32  write data (CPU register B).
- dm_data_out  out  32  read data, combinational from dm_addr.
- sw_in  in  16  asynchronous board switches.
- led_out  out  16  LED register contents.
- timer_irq  out  1  level, equals status match flag AND ctrl.irq_en.
- bus_err  out  1  registered one-cycle pulse after any write to an unmapped or read-only address.

## Operation

Address map (full 32-bit compare above bit 1):
- 0x0000_0000 .. (4·2^RAM_AW − 1): RAM, index = dm_addr[RAM_AW+1:2].
- 0xFFFF_0000 LED (RW; bits [15:0] used, reads zero-extended).
- 0xFFFF_0004 SW (RO; synchronised sw_in, zero-extended). A write here is an error.
- 0xFFFF_0008 TCNT (RW counter value).
- 0xFFFF_000C TCMP (RW compare value).
- 0xFFFF_0010 TCTL, with these bits:
  - bit0 en (RW);
  - bit1 auto_clr (RW);
  - bit2 irq_en (RW);
  - bit8 match (RO by value, W1C); a write of 1 clears it, 0 has no effect.
  - Other bits read 0.
- Any other address: reads return 0x0000_0000; writes are dropped and raise bus_err.

RAM:
- RAM is not cleared by rst; contents persist across reset and power-up are undefined.

Timer:
- Prescaler counter `pre` counts 0..PRESCALE−1 while en=1. A tick is generated when pre==PRESCALE−1, then pre wraps to 0.
- pre holds its value while en=0 and is cleared whenever TCNT is written.
- On a tick, TCNT increments modulo 2^32 (0xFFFF_FFFF → 0, no flag).
- Match condition: a tick occurs while TCNT==TCMP. Effects:
  - match is set;
  - if auto_clr=1, TCNT becomes 0 instead of incrementing.

Simultaneous events, priority highest first:
- CPU write to TCNT beats a tick increment or auto-clear.
- A match set beats a W1C clear in the same cycle (flag stays 1).
- A CPU write to TCMP takes effect for comparisons from the next cycle.

Switch input:
- sw_in passes through a 2-flop synchroniser before being readable.

## Timing

- Read latency 0: dm_data_out is combinational from dm_addr and current register/RAM state.
- Write latency 1: the value is visible on dm_data_out at the posedge where dm_write=1 is sampled, from that edge onward.
- Read-during-write to the same address shows old data before the edge and new data after it.
- sw_in change is visible at SW after 2 posedges (3 worst case for setup).
- bus_err asserts the cycle after the offending edge, for exactly one cycle.
- timer_irq follows match/irq_en with no extra register stage, so it rises in the cycle after the matching tick edge.
- Reset values while rst=1 and after release (clears immediately, without waiting for clk):
  - led_out=0, TCNT=0, TCMP=0, TCTL=0, pre=0, sync flops=0, bus_err=0, timer_irq=0;
  - dm_data_out follows the reset register values (SW reads 0).
- Reset mid-count aborts the timer immediately; RAM writes in the reset cycle are suppressed.

## Test plan

- RAM: write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 and 0x0000_0013 → both 0xDEADBEEF. Read 0x0000_0014 → unaffected.
- MMIO and errors:
  - write 0x1234_ABCD to LED → led_out=0xABCD, read LED=0x0000_ABCD;
  - write SW → bus_err pulse one cycle, SW value unchanged;
  - read 0x8000_0000 → 0.
- Timer match with auto-clear: PRESCALE=4, TCMP=3, TCTL=0x7. TCNT sequence is 0,1,2,3,0 with changes every 4 cycles. match=1 and timer_irq=1 after the tick where TCNT==3. Writing TCTL=0x107 → match cleared next cycle, en/auto_clr/irq_en retained.
- Priority cases:
  - W1C on the same edge as a match → match stays 1;
  - TCNT write 0x100 on the same edge as a tick → TCNT=0x100, prescaler restarts;
  - TCNT=0xFFFF_FFFF, TCMP=5, en=1 → wraps to 0 with match=0.
- Sync and reset: toggle sw_in=0x00F0 → SW reads 0x00F0 exactly after 2 edges. Assert rst asynchronously mid-count → TCNT, TCTL and led_out become 0 without a clock edge, and previously written RAM words still read back after release.
